// File: rtl/slc3_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : slc3_pkg
//  Description : Shared SLC-3 datapath types, register index constants and
//                condition-code encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package slc3_pkg;

    typedef logic [2:0]  reg_idx_t;
    typedef logic [15:0] word_t;

    localparam reg_idx_t R7_IDX = 3'd7;

    localparam logic [2:0] N_CC = 3'b100;
    localparam logic [2:0] Z_CC = 3'b010;
    localparam logic [2:0] P_CC = 3'b001;

    function automatic word_t sext5(input logic [4:0] imm);
        return {{11{imm[4]}}, imm};
    endfunction

endpackage
`default_nettype wire

// File: rtl/slc3_reg_file_nzp_gen.sv
`default_nettype none
// ============================================================================
//  Module      : nzp_gen
//  Description : Combinational bus value to one-hot {N,Z,P} condition code.
//  Revision    : 1.0 - initial release
// ============================================================================
module nzp_gen
    import slc3_pkg::*;
(
    input  word_t      bus_i,
    output logic [2:0] nzp_o
);

    always_comb begin
        nzp_o = P_CC;
        if (bus_i[15]) begin
            nzp_o = N_CC;
        end else if (bus_i == '0) begin
            nzp_o = Z_CC;
        end
    end

endmodule
`default_nettype wire

// File: rtl/slc3_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : slc3_reg_file
//  Description : SLC-3 eight-entry register file with SR1/SR2 operand muxes,
//                NZP condition codes and BEN branch-enable flag.
//                Optional macro REGFILE_BYPASS_EN enables write-through
//                forwarding from BUS to the register read ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module slc3_reg_file
    import slc3_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] BUS,
    input  logic [15:0] IR,
    input  logic        LD_REG,
    input  logic        LD_CC,
    input  logic        LD_BEN,
    input  logic        DRMUX,
    input  logic        SR1MUX,
    input  logic        SR2MUX,
    output logic [15:0] SR1_OUT,
    output logic [15:0] SR2_OUT,
    output logic [2:0]  NZP,
    output logic        BEN
);

    word_t      regs_q [8];
    logic [2:0] nzp_q;
    logic [2:0] nzp_d;
    logic       ben_q;
    logic       ben_d;

    reg_idx_t   w_dr;
    reg_idx_t   w_sr1;
    reg_idx_t   w_sr2;
    word_t      w_sr1_val;
    word_t      w_sr2_val;
    logic       w_unused;

    // Opcode and the imm/reg mode bit are decoded by the control FSM, not here.
    assign w_unused = ^{IR[15:12], IR[5]};

    assign w_dr  = DRMUX  ? R7_IDX   : IR[11:9];
    assign w_sr1 = SR1MUX ? IR[8:6]  : IR[11:9];
    assign w_sr2 = IR[2:0];

    nzp_gen u_nzp_gen (
        .bus_i (BUS),
        .nzp_o (nzp_d)
    );

    // BEN samples the condition codes held before this edge.
    assign ben_d = |(IR[11:9] & nzp_q);

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        w_sr1_val = regs_q[w_sr1];
        w_sr2_val = regs_q[w_sr2];
        if (LD_REG && (w_dr == w_sr1)) begin
            w_sr1_val = BUS;
        end
        if (LD_REG && (w_dr == w_sr2)) begin
            w_sr2_val = BUS;
        end
    end
`else
    always_comb begin
        w_sr1_val = regs_q[w_sr1];
        w_sr2_val = regs_q[w_sr2];
    end
`endif

    assign SR1_OUT = w_sr1_val;
    assign SR2_OUT = SR2MUX ? sext5(IR[4:0]) : w_sr2_val;
    assign NZP     = nzp_q;
    assign BEN     = ben_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
            nzp_q <= Z_CC;
            ben_q <= 1'b0;
        end else begin
            if (LD_REG) begin
                regs_q[w_dr] <= BUS;
            end
            if (LD_CC) begin
                nzp_q <= nzp_d;
            end
            if (LD_BEN) begin
                ben_q <= ben_d;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_slc3_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_slc3_reg_file
//  Description : Self-checking bench for slc3_reg_file against an array model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_slc3_reg_file;

    logic        Clk;
    logic        Reset;
    logic [15:0] BUS;
    logic [15:0] IR;
    logic        LD_REG;
    logic        LD_CC;
    logic        LD_BEN;
    logic        DRMUX;
    logic        SR1MUX;
    logic        SR2MUX;
    logic [15:0] SR1_OUT;
    logic [15:0] SR2_OUT;
    logic [2:0]  NZP;
    logic        BEN;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] m_r [8];
    logic [2:0]  m_nzp;
    logic        m_ben;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    slc3_reg_file dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .BUS     (BUS),
        .IR      (IR),
        .LD_REG  (LD_REG),
        .LD_CC   (LD_CC),
        .LD_BEN  (LD_BEN),
        .DRMUX   (DRMUX),
        .SR1MUX  (SR1MUX),
        .SR2MUX  (SR2MUX),
        .SR1_OUT (SR1_OUT),
        .SR2_OUT (SR2_OUT),
        .NZP     (NZP),
        .BEN     (BEN)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] ir, input logic [15:0] bus, input logic ldr,
                         input logic ldc, input logic ldb, input logic drm,
                         input logic s1m, input logic s2m, input logic rst);
        IR = ir; BUS = bus; LD_REG = ldr; LD_CC = ldc; LD_BEN = ldb;
        DRMUX = drm; SR1MUX = s1m; SR2MUX = s2m; Reset = rst;
    endtask

    // Expected outputs for the current inputs, straight from the read rules.
    task automatic check_outputs();
        int          sr1i, sr2i, dri, imm;
        logic [15:0] e1, e2, tmp;
        sr1i = SR1MUX ? int'(IR[8:6]) : int'(IR[11:9]);
        sr2i = int'(IR[2:0]);
        dri  = DRMUX ? 7 : int'(IR[11:9]);
        e1 = m_r[sr1i];
        if (BYPASS && LD_REG && dri == sr1i) e1 = BUS;
        if (SR2MUX) begin
            imm = int'(IR[4:0]);
            if (imm >= 16) imm = imm - 32;
            tmp = 16'(imm);
            e2 = tmp;
        end else begin
            e2 = m_r[sr2i];
            if (BYPASS && LD_REG && dri == sr2i) e2 = BUS;
        end
        check("sr1_out", SR1_OUT, e1);
        check("sr2_out", SR2_OUT, e2);
        check("nzp", {13'd0, NZP}, {13'd0, m_nzp});
        check("ben", {15'd0, BEN}, {15'd0, m_ben});
    endtask

    task automatic tick();
        logic       nb;
        int         dri;
        logic [2:0] cc_sel;
        @(posedge Clk);
        if (Reset) begin
            for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
            m_nzp = 3'b010;
            m_ben = 1'b0;
        end else begin
            cc_sel = IR[11:9];
            nb = (cc_sel & m_nzp) != 3'b000;
            dri = DRMUX ? 7 : int'(IR[11:9]);
            if (LD_BEN) m_ben = nb;
            if (LD_CC) begin
                if (BUS[15])          m_nzp = 3'b100;
                else if (BUS == 0)    m_nzp = 3'b010;
                else                  m_nzp = 3'b001;
            end
            if (LD_REG) m_r[dri] = BUS;
        end
        #1;
    endtask

    task automatic step(input logic [15:0] ir, input logic [15:0] bus, input logic ldr,
                        input logic ldc, input logic ldb, input logic drm,
                        input logic s1m, input logic s2m, input logic rst);
        drive(ir, bus, ldr, ldc, ldb, drm, s1m, s2m, rst);
        #1;
        if (!rst) check_outputs();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) m_r[i] = 16'hxxxx;
        m_nzp = 3'bxxx;
        m_ben = 1'bx;
        drive(16'h0, 16'h0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge Clk);
        step(16'h0, 16'h0, 0, 0, 0, 0, 0, 0, 1);

        // Reset state: every register reads zero through both ports.
        for (int i = 0; i < 8; i++) begin
            step(16'(i << 6) | 16'(i), 16'h0, 0, 0, 0, 0, 1, 0, 0);
            check("reset_sr1", SR1_OUT, 16'h0000);
            check("reset_sr2", SR2_OUT, 16'h0000);
        end
        check("reset_nzp", {13'd0, NZP}, 16'h0002);
        check("reset_ben", {15'd0, BEN}, 16'h0000);

        // Write R3 then read it back; neighbours stay zero.
        step(16'(3 << 9), 16'hBEEF, 1, 0, 0, 0, 0, 0, 0);
        step(16'(3 << 9) | 16'h0004, 16'h0, 0, 0, 0, 0, 0, 0, 0);
        check("r3_readback", SR1_OUT, 16'hBEEF);
        check("r4_untouched", SR2_OUT, 16'h0000);

        // R7 via DRMUX and the sign-extended immediate path.
        step(16'h0000, 16'h1234, 1, 0, 0, 1, 0, 0, 0);
        step(16'(7 << 6) | 16'h0016, 16'h0, 0, 0, 0, 0, 1, 1, 0);
        check("r7_readback", SR1_OUT, 16'h1234);
        check("imm5_sext", SR2_OUT, 16'hFFF6);

        // Condition-code coding.
        step(16'h0, 16'h8000, 0, 1, 0, 0, 0, 0, 0);
        check("cc_neg", {13'd0, NZP}, 16'h0004);
        step(16'h0, 16'h0000, 0, 1, 0, 0, 0, 0, 0);
        check("cc_zero", {13'd0, NZP}, 16'h0002);
        step(16'h0, 16'h0001, 0, 1, 0, 0, 0, 0, 0);
        check("cc_pos", {13'd0, NZP}, 16'h0001);

        // BEN uses the NZP held before the same-edge CC update.
        step(16'(1 << 9), 16'h8000, 0, 1, 1, 0, 1, 1, 0);
        check("ben_old_nzp", {15'd0, BEN}, 16'h0001);
        check("nzp_after_ben", {13'd0, NZP}, 16'h0004);
        step(16'(1 << 9), 16'h0000, 0, 0, 1, 0, 1, 1, 0);
        check("ben_clear", {15'd0, BEN}, 16'h0000);

        // Same-cycle write and read of R2.
        drive(16'(2 << 9), 16'h00AA, 1, 0, 0, 0, 0, 0, 0);
        #1;
        check_outputs();
        check("r2_same_cycle", SR1_OUT, BYPASS ? 16'h00AA : 16'h0000);
        tick();
        step(16'(2 << 9), 16'h0, 0, 0, 0, 0, 0, 0, 0);
        check("r2_written", SR1_OUT, 16'h00AA);

        // Reset wins over a concurrent load.
        step(16'(2 << 9), 16'h5555, 1, 1, 1, 0, 0, 0, 1);
        step(16'(2 << 9), 16'h0, 0, 0, 0, 0, 0, 0, 0);
        check("r2_reset_dominates", SR1_OUT, 16'h0000);
        check("nzp_reset_dominates", {13'd0, NZP}, 16'h0002);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [15:0] rbus;
            case ($urandom_range(0, 3))
                0:       rbus = 16'h0000;
                1:       rbus = 16'h8000 | 16'($urandom);
                default: rbus = 16'($urandom);
            endcase
            step(16'($urandom), rbus, 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 31) == 0));
        end

        drive(16'h0, 16'h0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
